// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared constants and helpers for the UART receive path.
//   BAUD6M_CLK24M  : clk cycles per bit for 6 Mbaud from a 24 MHz clock
//   UART_DATA_BITS : payload bits per frame
//   expected_parity: parity bit a correct transmitter would send for a byte
package uart_rx_pkg;

  localparam int unsigned BAUD6M_CLK24M  = 4;
  localparam int unsigned UART_DATA_BITS = 8;

  // odd = 0 -> even parity (bit = ^data); odd = 1 -> odd parity (bit = ~^data)
  function automatic logic expected_parity(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-stage synchronizer for a single asynchronous input. Both stages reset to
// ResetVal so an idle-high line reads as idle straight out of reset.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (two clk of latency)
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {2{ResetVal}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// Receive half of the inter-FPGA UART link.
// Frame: START(0), DATA[7:0] LSB first, PARITY, STOP(1); line idles high.
// Ports:
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset, aborts any frame in flight
//   i_rx         : UART line, asynchronous to i_clk
//   o_data_rx    : last byte received with a good stop bit, held until next o_rx_valid
//   o_rx_valid   : one-cycle pulse, o_data_rx updated
//   o_parity_err : one-cycle pulse alongside o_rx_valid when parity mismatched
//   o_frame_err  : one-cycle pulse when the stop bit sampled low (no o_rx_valid)
//   o_rx_busy    : high from start-bit detect until return to idle
// BAUD_RATE is clk cycles per bit and must be >= 4.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_RATE = BAUD6M_CLK24M,
  parameter int unsigned PARITY    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_data_rx,
  output logic                      o_rx_valid,
  output logic                      o_parity_err,
  output logic                      o_frame_err,
  output logic                      o_rx_busy
);

  localparam int unsigned CntW = $clog2(BAUD_RATE);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_RATE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(BAUD_RATE - 1);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e                    r_state;
  logic [CntW-1:0]           r_bit_cnt;
  logic [IdxW-1:0]           r_idx;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic                      r_p_bit;
  logic [1:0]                r_settle;
  logic                      r_armed;
  logic [UART_DATA_BITS-1:0] r_data_rx;
  logic                      r_rx_valid;
  logic                      r_parity_err;
  logic                      r_frame_err;
  logic                      r_rx_busy;

  logic w_rx_s;
  logic w_half_pt;
  logic w_full_pt;
  logic w_exp_par;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync_rx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx),
    .o_q    (w_rx_s)
  );

  assign w_half_pt = (r_bit_cnt == HalfLast);
  assign w_full_pt = (r_bit_cnt == FullLast);
  assign w_exp_par = expected_parity(r_shreg, PARITY != 0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_p_bit      <= 1'b0;
      r_settle     <= '0;
      r_armed      <= 1'b0;
      r_data_rx    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_busy    <= 1'b0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      // The synchronizer holds its reset value for two clocks. Only a high
      // level seen after that arms start detection, so a line that is low
      // across reset release needs a fresh falling edge before a frame starts.
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rx_s) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (r_armed && !w_rx_s) begin
            r_state   <= StStart;
            r_bit_cnt <= '0;
            r_rx_busy <= 1'b1;
          end
        end

        StStart: begin
          if (w_half_pt) begin
            r_bit_cnt <= '0;
            if (w_rx_s) begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              r_state   <= StIdle;
              r_rx_busy <= 1'b0;
            end else begin
              r_state <= StData;
              r_idx   <= '0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
          end
        end

        StData: begin
          if (w_full_pt) begin
            r_bit_cnt <= '0;
            r_shreg   <= {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
            r_idx     <= r_idx + IdxW'(1);
            if (r_idx == IdxLast) begin
              r_state <= StParity;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
          end
        end

        StParity: begin
          if (w_full_pt) begin
            r_bit_cnt <= '0;
            r_p_bit   <= w_rx_s;
            r_state   <= StStop;
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
          end
        end

        StStop: begin
          if (w_full_pt) begin
            r_bit_cnt <= '0;
            if (w_rx_s) begin
              // Back to idle at mid-stop so a following start edge is not missed.
              r_data_rx    <= r_shreg;
              r_rx_valid   <= 1'b1;
              r_parity_err <= (r_p_bit != w_exp_par);
              r_state      <= StIdle;
              r_rx_busy    <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StBreak;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
          end
        end

        StBreak: begin
          // A held-low line reports one frame error, then waits here silently.
          if (w_rx_s) begin
            r_state   <= StIdle;
            r_rx_busy <= 1'b0;
          end
        end

        default: begin
          r_state   <= StIdle;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_rx    = r_data_rx;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_rx_busy    = r_rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Drives one serial line into two receivers (even and odd parity) and checks
// every delivered byte against expectations queued when each frame is sent.
module tb_uart_rx;

  localparam int unsigned Baud = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_e, data_o;
  logic       val_e, val_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_RATE(Baud),
    .PARITY   (0)
  ) u_dut_even (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data_rx   (data_e),
    .o_rx_valid  (val_e),
    .o_parity_err(perr_e),
    .o_frame_err (ferr_e),
    .o_rx_busy   (busy_e)
  );

  uart_rx #(
    .BAUD_RATE(Baud),
    .PARITY   (1)
  ) u_dut_odd (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data_rx   (data_o),
    .o_rx_valid  (val_o),
    .o_parity_err(perr_o),
    .o_frame_err (ferr_o),
    .o_rx_busy   (busy_o)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  exp_t x_e, x_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_val_e  = 0;
  int n_val_o  = 0;
  int n_ferr_e = 0;
  int n_ferr_o = 0;
  int lat      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives bits[0..nbits-1] of {stop, parity, data, start}; a full good frame
  // queues its expected results for both receivers.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic e_perr, input logic o_perr, input int nbits = 11);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    if (stop && nbits == 11) begin
      q_e.push_back({d, e_perr});
      q_o.push_back({d, o_perr});
    end
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (Baud) @(negedge clk);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (val_e) begin
        n_val_e++;
        if (q_e.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL even_unexpected_valid: data_rx=%0h with no frame queued", data_e);
        end else begin
          x_e = q_e.pop_front();
          check("even_data", 32'(data_e), 32'(x_e.data));
          check("even_perr", 32'(perr_e), 32'(x_e.perr));
        end
      end
      if (ferr_e) begin
        n_ferr_e++;
        check("even_ferr_no_valid", 32'(val_e), 32'(0));
      end
      if (val_o) begin
        n_val_o++;
        if (q_o.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL odd_unexpected_valid: data_rx=%0h with no frame queued", data_o);
        end else begin
          x_o = q_o.pop_front();
          check("odd_data", 32'(data_o), 32'(x_o.data));
          check("odd_perr", 32'(perr_o), 32'(x_o.perr));
        end
      end
      if (ferr_o) begin
        n_ferr_o++;
        check("odd_ferr_no_valid", 32'(val_o), 32'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_e", 32'(data_e), 32'(0));
    check("rst_flags_e", 32'({val_e, perr_e, ferr_e, busy_e}), 32'(0));
    check("rst_data_o", 32'(data_o), 32'(0));
    check("rst_flags_o", 32'({val_o, perr_o, ferr_o, busy_o}), 32'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1. Clean A5 (4 ones, parity 0): good for even, mismatch for odd.
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!val_e && lat < 200);
      end
    join
    check("t1_latency_in_window", 32'(lat >= 86 && lat <= 88), 32'(1));
    check("t1_one_valid", 32'(n_val_e), 32'(1));
    check("t1_busy_idle", 32'(busy_e), 32'(0));

    // 2. 3C with corrupted parity bit 1.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (Baud) @(negedge clk);
    check("t2_valid_count", 32'(n_val_e), 32'(2));
    check("t2_data_hold", 32'(data_e), 32'(8'h3C));

    // 3. 55 with stop bit 0, then line held low for 30 bits.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30 * Baud) @(negedge clk);
    check("t3_busy_in_break", 32'(busy_e), 32'(1));
    check("t3_ferr_once_e", 32'(n_ferr_e), 32'(1));
    check("t3_ferr_once_o", 32'(n_ferr_o), 32'(1));
    check("t3_no_valid", 32'(n_val_e), 32'(2));
    check("t3_data_kept_e", 32'(data_e), 32'(8'h3C));
    check("t3_data_kept_o", 32'(data_o), 32'(8'h3C));
    rx = 1'b1;
    repeat (Baud) @(negedge clk);
    check("t3_busy_drop_e", 32'(busy_e), 32'(0));
    check("t3_busy_drop_o", 32'(busy_o), 32'(0));

    // 4. Low glitch of Baud/4 clk.
    rx = 1'b0;
    repeat (Baud / 4) @(negedge clk);
    rx = 1'b1;
    repeat (Baud) @(negedge clk);
    check("t4_busy_idle", 32'(busy_e), 32'(0));
    check("t4_no_pulses", 32'(n_val_e + n_ferr_e), 32'(3));

    // 5. Back-to-back frames, then odd-weight 07 with each parity choice.
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2 * Baud) @(negedge clk);
    check("t5_valid_count", 32'(n_val_e), 32'(7));

    // 6. Reset mid-DATA of F0.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
    check("t6_busy_before_rst", 32'(busy_e), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_e", 32'({data_e, val_e, perr_e, ferr_e, busy_e}), 32'(0));
    check("t6_rst_o", 32'({data_o, val_o, perr_o, ferr_o, busy_o}), 32'(0));
    // Line held low across reset release must not start a frame.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * Baud) @(negedge clk);
    check("t6_low_after_rst_idle", 32'(busy_e | busy_o), 32'(0));
    check("t6_low_after_rst_noerr", 32'(n_ferr_e + n_ferr_o), 32'(2));
    rx = 1'b1;
    repeat (Baud) @(negedge clk);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4 * Baud) @(negedge clk);

    check("end_queue_e_empty", 32'(q_e.size()), 32'(0));
    check("end_queue_o_empty", 32'(q_o.size()), 32'(0));
    check("end_valid_e", 32'(n_val_e), 32'(8));
    check("end_valid_o", 32'(n_val_o), 32'(8));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
